// File: rtl/bin_to_bcd_disp.sv
// Purpose : sequential double-dabble binary-to-BCD converter driving six active-low 7-seg displays.
// Latency : WIDTH+2 edges from a bin_in change to registered bcd_out/hex_out and the done pulse.
// Backpr. : none; bin_in changes during a conversion are ignored and re-compared on the next idle cycle.
//
// Ports:
//   clk      in   rising-edge clock for all logic
//   rst_n    in   synchronous active-low reset
//   bin_in   in   [WIDTH-1:0]     binary value to display
//   bcd_out  out  [4*DIGITS-1:0]  BCD digits, digit 0 (units) in [3:0]
//   hex_out  out  [7*DIGITS-1:0]  seven-seg codes, gfedcba, active-low, digit i at [7i+6:7i]
//   busy     out  conversion in progress
//   done     out  one-cycle pulse when bcd_out/hex_out update
//   ovf      out  last converted value exceeded 10^DIGITS-1 (bcd_out then holds value mod 10^DIGITS)
// Optional: define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero digit.
// DIGITS must satisfy 4*DIGITS >= WIDTH + ceil(WIDTH/3).

module bin_to_bcd_disp #(
    parameter int WIDTH  = 18,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0]         MAX_VAL  = pow10(DIGITS) - 64'd1;
    localparam logic [7*DIGITS-1:0] HEX_ZERO = {DIGITS{7'b1000000}};

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     last_q,  last_d;
    logic [SH_W-1:0]      shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [BCD_W-1:0]     bcd_q,   bcd_d;
    logic [7*DIGITS-1:0]  hex_q,   hex_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic                 ovf_q,   ovf_d;

    logic [SH_W-1:0]      adj;
    logic [3:0]           dig;
`ifdef LEADING_ZERO_BLANK_EN
    logic                 seen_nz;
`endif

    // State register (all flops)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            hex_q   <= HEX_ZERO;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bin_in != last_q) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath / registered-output next values
    always_comb begin
        last_d  = last_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        adj     = shreg_q;
        dig     = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
        seen_nz = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bin_in != last_q) begin
                    last_d  = bin_in;
                    shreg_d = {{BCD_W{1'b0}}, bin_in};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                // Add-3 correction on every BCD nibble in parallel, then shift the whole register.
                for (int i = 0; i < DIGITS; i++) begin
                    if (adj[WIDTH + 4*i +: 4] >= 4'd5)
                        adj[WIDTH + 4*i +: 4] = adj[WIDTH + 4*i +: 4] + 4'd3;
                end
                shreg_d = {adj[SH_W-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                bcd_d = shreg_q[SH_W-1 -: BCD_W];
                // Walk from the top digit down so blanking stops at the first nonzero digit.
                for (int i = DIGITS - 1; i >= 0; i--) begin
                    dig = shreg_q[WIDTH + 4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                    if (dig != 4'd0) seen_nz = 1'b1;
                    hex_d[7*i +: 7] = (seen_nz || i == 0) ? seg_decode(dig) : 7'b1111111;
`else
                    hex_d[7*i +: 7] = seg_decode(dig);
`endif
                end
                ovf_d  = (64'(last_q) > MAX_VAL);
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Outputs come straight from flops; nothing combinational from bin_in.
    assign bcd_out = bcd_q;
    assign hex_out = hex_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_disp.sv
module tb_bin_to_bcd_disp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] bin_in;
    logic [23:0] bcd_out;
    logic [41:0] hex_out;
    logic        busy;
    logic        done;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    localparam logic [41:0] HEX_ZERO = {6{7'b1000000}};

    bin_to_bcd_disp #(.WIDTH(18), .DIGITS(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bin_in  (bin_in),
        .bcd_out (bcd_out),
        .hex_out (hex_out),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected display for a BCD word, with leading-zero blanking when the feature is built in.
    function automatic logic [41:0] hexv(input logic [23:0] b);
        logic [41:0] r;
        logic        seen;
        logic [3:0]  d;
        r    = '0;
        seen = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            d = b[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (d != 4'd0) seen = 1'b1;
            r[7*i +: 7] = (seen || i == 0) ? seg(d) : 7'b1111111;
`else
            r[7*i +: 7] = seg(d);
`endif
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Waits (bounded) for done; checks edge count, results, and that done drops the next cycle.
    task automatic wait_done(input string tag, input logic [23:0] exp_bcd, input int exp_lat);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 45) begin
            tick();
            n++;
            if (done === 1'b1) got = 1'b1;
        end
        chk({tag, "_lat"},  64'(n),  64'(exp_lat));
        chk({tag, "_bcd"},  64'(bcd_out), 64'(exp_bcd));
        chk({tag, "_hex"},  64'(hex_out), 64'(hexv(exp_bcd)));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_ovf"},  64'(ovf),  64'd0);
        tick();
        chk({tag, "_done_drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        int spurious;

        // Reset with bin_in = 0
        rst_n  = 1'b0;
        bin_in = 18'd0;
        tick();
        tick();
        chk("rst_bcd",  64'(bcd_out), 64'd0);
        chk("rst_hex",  64'(hex_out), 64'(HEX_ZERO));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf",  64'(ovf),  64'd0);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) spurious++;
        end
        chk("rst_no_conv", 64'(spurious), 64'd0);

        // Maximum value: busy after edges 1..19, done only after edge 20
        bin_in = 18'd262143;
        spurious = 0;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0) spurious++;
        end
        chk("max_busy_window", 64'(spurious), 64'd0);
        tick();
        chk("max_done", 64'(done), 64'd1);
        chk("max_busy_low", 64'(busy), 64'd0);
        chk("max_bcd",  64'(bcd_out), 64'h262143);
        chk("max_hex",  64'(hex_out),
            64'({7'b0100100, 7'b0000010, 7'b0100100, 7'b1111001, 7'b0011001, 7'b0110000}));
        chk("max_ovf",  64'(ovf), 64'd0);
        tick();
        chk("max_done_drop", 64'(done), 64'd0);

        // Change mid-conversion: 12345, then 999 before edge 8
        bin_in = 18'd12345;
        repeat (7) tick();
        bin_in = 18'd999;
        wait_done("mid1", 24'h012345, 13);
        chk("mid_retrig_busy", 64'(busy), 64'd1);
        wait_done("mid2", 24'h000999, 19);

        // Return to zero
        bin_in = 18'd500;
        wait_done("z500", 24'h000500, 20);
        bin_in = 18'd0;
        wait_done("z0", 24'h000000, 20);
`ifdef LEADING_ZERO_BLANK_EN
        chk("z0_blank", 64'(hex_out), 64'({{5{7'b1111111}}, 7'b1000000}));
`else
        chk("z0_allzero", 64'(hex_out), 64'(HEX_ZERO));
`endif
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        chk("z0_single_done", 64'(spurious), 64'd0);

        // Leading zeros (blanked only when the feature is built in)
        bin_in = 18'd1007;
        wait_done("d1007", 24'h001007, 20);
`ifdef LEADING_ZERO_BLANK_EN
        chk("d1007_hex", 64'(hex_out),
            64'({7'b1111111, 7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1111000}));
`else
        chk("d1007_hex", 64'(hex_out),
            64'({7'b1000000, 7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1111000}));
`endif

        // Reset in the middle of a SHIFT phase
        bin_in = 18'd77777;
        repeat (9) tick();
        chk("rmid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("rmid_bcd",  64'(bcd_out), 64'd0);
        chk("rmid_hex",  64'(hex_out), 64'(HEX_ZERO));
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_done", 64'(done), 64'd0);
        chk("rmid_ovf",  64'(ovf),  64'd0);
        rst_n = 1'b1;
        wait_done("rmid_conv", 24'h077777, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
